// File: rtl/wb_pkg.sv
// Shared configuration and types for the register-file writeback arbiter.
package wb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREQ = 3;
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [IDXW-1:0] req_idx_t;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at the pointer and wraps,
// returning a one-hot grant and the pointer value that follows it.
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_idx_o,
    output logic            gnt_any_o,
    output logic [PW-1:0]   ptr_next_o
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_o      = '0;
        gnt_idx_o  = '0;
        gnt_any_o  = 1'b0;
        idx        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr_i) + k) % NREQ);
            if (!gnt_any_o && valid_i[idx]) begin
                gnt_any_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
        ptr_next_o = ptr_i;
        if (gnt_any_o) begin
            ptr_next_o = (32'(gnt_idx_o) + 1 == NREQ) ? '0 : PW'(32'(gnt_idx_o) + 1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback units (round-robin,
// one registered write per cycle) and tracks pending writes for RAW stalls.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = wb_pkg::XLEN,
    parameter int unsigned AW   = wb_pkg::AW,
    parameter int unsigned NREQ = wb_pkg::NREQ
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rf_wr_en,
    output logic [AW-1:0]        rf_w1,
    output logic [XLEN-1:0]      rf_data
);

    localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NREGS = 2 ** AW;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [AW-1:0]    sel_addr;
    logic [XLEN-1:0]  sel_data;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    w1_q, w1_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [NREGS-1:0] sb_q, sb_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .valid_i    (req_valid),
        .ptr_i      (ptr_q),
        .gnt_o      (req_ready),
        .gnt_idx_o  (gnt_idx),
        .gnt_any_o  (gnt_any),
        .ptr_next_o (ptr_d)
    );

    assign sel_addr = req_addr[32'(gnt_idx) * AW +: AW];
    assign sel_data = req_data[32'(gnt_idx) * XLEN +: XLEN];

    // A grant to x0 is consumed but never reaches the register file.
    always_comb begin
        wr_en_d = 1'b0;
        w1_d    = w1_q;
        data_d  = data_q;
        if (gnt_any && (sel_addr != '0)) begin
            wr_en_d = 1'b1;
            w1_d    = sel_addr;
            data_d  = sel_data;
        end
    end

    // Set after clear so a newly issued writer keeps ownership of the register.
    always_comb begin
        sb_d = sb_q;
        if (wr_en_q) begin
            sb_d[w1_q] = 1'b0;
        end
        if (alloc_en) begin
            sb_d[alloc_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            wr_en_q <= 1'b0;
            w1_q    <= '0;
            data_q  <= '0;
            sb_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wr_en_q <= wr_en_d;
            w1_q    <= w1_d;
            data_q  <= data_d;
            sb_q    <= sb_d;
        end
    end

    assign rs1_busy = sb_q[rs1];
    assign rs2_busy = sb_q[rs2];
    assign rf_wr_en = wr_en_q;
    assign rf_w1    = w1_q;
    assign rf_data  = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREQ = 3;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 rf_wr_en;
    logic [AW-1:0]        rf_w1;
    logic [XLEN-1:0]      rf_data;

    int n_cmp;
    int n_err;

    // Reference model state
    int          m_ptr;
    bit          m_wr_en;
    logic [AW-1:0]   m_w1;
    logic [XLEN-1:0] m_data;
    bit          m_sb [2**AW];

    regfile_wb_arbiter #(
        .XLEN (XLEN),
        .AW   (AW),
        .NREQ (NREQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rf_wr_en   (rf_wr_en),
        .rf_w1      (rf_w1),
        .rf_data    (rf_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [XLEN-1:0] d);
        req_valid[i]              = v;
        req_addr[i*AW +: AW]      = a;
        req_data[i*XLEN +: XLEN]  = d;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_wr_en = 1'b0;
        m_w1    = '0;
        m_data  = '0;
        for (int r = 0; r < 2**AW; r++) m_sb[r] = 1'b0;
    endtask

    // Priority list begins at the pointer and wraps around the requesters.
    function automatic int exp_grant();
        int order[$];
        for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
        foreach (order[j]) if (req_valid[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock with reset released, updating the model from the pre-edge inputs.
    task automatic step();
        int g;
        logic [AW-1:0] a;
        g = exp_grant();
        @(posedge clk);
        if (m_wr_en) m_sb[m_w1] = 1'b0;
        if (alloc_en && alloc_addr != 0) m_sb[alloc_addr] = 1'b1;
        m_wr_en = 1'b0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            a = req_addr[g*AW +: AW];
            if (a != 0) begin
                m_wr_en = 1'b1;
                m_w1    = a;
                m_data  = req_data[g*XLEN +: XLEN];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        alloc_en   = 1'b1;
        alloc_addr = 5'd9;
        rs1        = 5'd9;
        rs2        = 5'd0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), $urandom);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++;
            $display("FAIL reset_wr_en: got %0h want 0", rf_wr_en); end
        n_cmp++; if (rf_w1 !== '0) begin n_err++;
            $display("FAIL reset_w1: got %0h want 0", rf_w1); end
        n_cmp++; if (rf_data !== '0) begin n_err++;
            $display("FAIL reset_data: got %0h want 0", rf_data); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: got %0h want 0", rs1_busy); end
        n_cmp++; if (req_ready !== 3'b001) begin n_err++;
            $display("FAIL reset_ready: got %0h want 1", req_ready); end
        alloc_en = 1'b0;
        rst      = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++;
            $display("FAIL release_first_grant: got %0h want 1", req_ready); end
        step();
        n_cmp++; if (rf_wr_en !== 1'b1 || rf_w1 !== 5'd1) begin n_err++;
            $display("FAIL release_first_write: got en=%0h w1=%0h want en=1 w1=1", rf_wr_en, rf_w1); end
        req_valid = '0;
        step();
    endtask

    task automatic test_single_write();
        req_valid = '0;
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++;
            $display("FAIL single_ready: got %0h want 2", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if (rf_wr_en !== 1'b1 || rf_w1 !== 5'd5 || rf_data !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL single_write: got en=%0h w1=%0h d=%0h want en=1 w1=5 d=deadbeef",
                     rf_wr_en, rf_w1, rf_data); end
        step();
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++;
            $display("FAIL single_idle: got %0h want 0", rf_wr_en); end
    endtask

    task automatic test_round_robin();
        // Park the pointer at requester 0 first.
        req_valid = '0;
        set_req(m_ptr == 0 ? 0 : (m_ptr + NREQ - 1) % NREQ, 1'b1, 5'd20, 32'h1);
        if (m_ptr != 0) begin
            req_valid = '0;
            set_req(NREQ - 1, 1'b1, 5'd20, 32'h1);
            step();
        end
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA0 + i);
        #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (req_ready !== NREQ'(1 << (i % 3))) begin n_err++;
                $display("FAIL rr_order[%0d]: got %0h want %0h", i, req_ready, 1 << (i % 3)); end
            if (i > 0) begin
                n_cmp++; if (rf_wr_en !== 1'b1 || rf_w1 !== AW'(((i - 1) % 3) + 1)) begin n_err++;
                    $display("FAIL rr_write[%0d]: got en=%0h w1=%0h want en=1 w1=%0h",
                             i, rf_wr_en, rf_w1, ((i - 1) % 3) + 1); end
            end
            step();
        end
        n_cmp++; if (rf_wr_en !== 1'b1 || rf_w1 !== 5'd3 || rf_data !== 32'hA2) begin n_err++;
            $display("FAIL rr_last: got en=%0h w1=%0h d=%0h want en=1 w1=3 d=a2",
                     rf_wr_en, rf_w1, rf_data); end
        req_valid = '0;
        step();
    endtask

    task automatic test_x0_drop();
        req_valid = '0;
        set_req(0, 1'b1, 5'd0, 32'h55);
        set_req(1, 1'b1, 5'd11, 32'h1111);
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++;
            $display("FAIL x0_ready: got %0h want 1", req_ready); end
        step();
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++;
            $display("FAIL x0_no_write: got %0h want 0", rf_wr_en); end
        n_cmp++; if (req_ready !== 3'b010) begin n_err++;
            $display("FAIL x0_next_grant: got %0h want 2", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if (rf_wr_en !== 1'b1 || rf_w1 !== 5'd11 || rf_data !== 32'h1111) begin n_err++;
            $display("FAIL x0_follow_write: got en=%0h w1=%0h d=%0h want en=1 w1=b d=1111",
                     rf_wr_en, rf_w1, rf_data); end
        step();
    endtask

    task automatic test_scoreboard();
        req_valid  = '0;
        rs1        = 5'd7;
        rs2        = 5'd0;
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
        #1;
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++;
            $display("FAIL sb_before_alloc: got %0h want 0", rs1_busy); end
        step();
        alloc_en = 1'b0;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++;
            $display("FAIL sb_after_alloc: got %0h want 1", rs1_busy); end
        repeat (2) step();
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++;
            $display("FAIL sb_hold: got %0h want 1", rs1_busy); end
        set_req(m_ptr, 1'b1, 5'd7, 32'h7777);
        step();
        req_valid = '0;
        n_cmp++; if (rf_wr_en !== 1'b1 || rf_w1 !== 5'd7 || rs1_busy !== 1'b1) begin n_err++;
            $display("FAIL sb_during_write: got en=%0h w1=%0h busy=%0h want en=1 w1=7 busy=1",
                     rf_wr_en, rf_w1, rs1_busy); end
        step();
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++;
            $display("FAIL sb_cleared: got %0h want 0", rs1_busy); end
        // Realloc on the same edge as the clear: newer writer keeps it busy.
        alloc_en = 1'b1;
        step();
        alloc_en = 1'b0;
        set_req(m_ptr, 1'b1, 5'd7, 32'h7070);
        step();
        req_valid  = '0;
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
        n_cmp++; if (rf_wr_en !== 1'b1 || rs1_busy !== 1'b1) begin n_err++;
            $display("FAIL sb_race_setup: got en=%0h busy=%0h want en=1 busy=1", rf_wr_en, rs1_busy); end
        step();
        alloc_en = 1'b0;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++;
            $display("FAIL sb_set_wins: got %0h want 1", rs1_busy); end
        set_req(m_ptr, 1'b1, 5'd7, 32'h0707);
        step();
        req_valid = '0;
        step();
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++;
            $display("FAIL sb_final_clear: got %0h want 0", rs1_busy); end
        alloc_en   = 1'b1;
        alloc_addr = 5'd0;
        step();
        alloc_en = 1'b0;
        n_cmp++; if (rs2_busy !== 1'b0) begin n_err++;
            $display("FAIL sb_x0: got %0h want 0", rs2_busy); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, ($urandom_range(0, 9) < 6),
                        ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                        $urandom);
            end
            alloc_en   = ($urandom_range(0, 3) == 0);
            alloc_addr = AW'($urandom_range(0, 31));
            rs1        = AW'($urandom_range(0, 31));
            rs2        = AW'($urandom_range(0, 31));
            #1;
            n_cmp++; if (req_ready !== exp_ready()) begin n_err++;
                $display("FAIL rand_ready[%0d]: got %0h want %0h", c, req_ready, exp_ready()); end
            n_cmp++; if (rs1_busy !== m_sb[rs1] || rs2_busy !== m_sb[rs2]) begin n_err++;
                $display("FAIL rand_busy[%0d]: got %0h/%0h want %0h/%0h",
                         c, rs1_busy, rs2_busy, m_sb[rs1], m_sb[rs2]); end
            n_cmp++; if (rf_wr_en !== m_wr_en) begin n_err++;
                $display("FAIL rand_wr_en[%0d]: got %0h want %0h", c, rf_wr_en, m_wr_en); end
            if (m_wr_en) begin
                n_cmp++; if (rf_w1 !== m_w1 || rf_data !== m_data) begin n_err++;
                    $display("FAIL rand_write[%0d]: got w1=%0h d=%0h want w1=%0h d=%0h",
                             c, rf_w1, rf_data, m_w1, m_data); end
            end
            step();
        end
        req_valid = '0;
        alloc_en  = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_midop();
        alloc_en   = 1'b1;
        alloc_addr = 5'd12;
        rs1        = 5'd12;
        step();
        alloc_en  = 1'b0;
        req_valid = '0;
        set_req(m_ptr, 1'b1, 5'd12, 32'hCAFE0012);
        step();
        req_valid = '0;
        n_cmp++; if (rf_wr_en !== 1'b1 || rs1_busy !== 1'b1) begin n_err++;
            $display("FAIL midop_setup: got en=%0h busy=%0h want en=1 busy=1", rf_wr_en, rs1_busy); end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (rf_wr_en !== 1'b0 || rf_w1 !== '0 || rf_data !== '0) begin n_err++;
            $display("FAIL midop_outputs: got en=%0h w1=%0h d=%0h want all 0", rf_wr_en, rf_w1, rf_data); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++;
            $display("FAIL midop_sb: got %0h want 0", rs1_busy); end
        #1;
        rst = 1'b1;
        step();
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++;
            $display("FAIL midop_no_replay: got %0h want 0", rf_wr_en); end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'h0);
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++;
            $display("FAIL midop_ptr: got %0h want 1", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        rs1        = '0;
        rs2        = '0;
        model_reset();
        test_reset();
        test_single_write();
        test_round_robin();
        test_x0_drop();
        test_scoreboard();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
